// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Main control FSM for a multicycle LEGv8 datapath. Decodes
//                IR[31:21], sequences the instruction phases, drives datapath
//                muxes/enables and ALUOp, counts retired instructions and
//                flags unsupported opcodes.
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_control #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [10:0]      opcode,
   input  logic             zero,
   output logic             pc_write,
   output logic             pc_write_cond,
   output logic             ir_write,
   output logic             mem_read,
   output logic             mem_write,
   output logic             reg_write,
   output logic             mem_to_reg,
   output logic             reg2_loc,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       pc_source,
   output logic             alu_op1,
   output logic             alu_op0,
   output logic             illegal,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEM_ADDR = 4'd2,
      MEM_RD   = 4'd3,
      MEM_WB   = 4'd4,
      MEM_WR   = 4'd5,
      R_EXEC   = 4'd6,
      R_WB     = 4'd7,
      CBZ      = 4'd8,
      BR       = 4'd9,
      HALT     = 4'd10
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       ir_write;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       mem_to_reg;
      logic       reg2_loc;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_source;
      logic       alu_op1;
      logic       alu_op0;
   } ctrl_t;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Moore control word for each state; anything not set stays 0.
   function automatic ctrl_t ctrl_of(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         FETCH: begin
            c.mem_read = 1'b1; c.ir_write = 1'b1; c.pc_write = 1'b1;
            c.alu_src_b = 2'b01;
         end
         DECODE:   c.alu_src_b = 2'b11;
         MEM_ADDR: begin
            c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.reg2_loc = 1'b1;
         end
         MEM_RD:   c.mem_read = 1'b1;
         MEM_WB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
         MEM_WR:   begin c.mem_write = 1'b1; c.reg2_loc = 1'b1; end
         R_EXEC:   begin c.alu_src_a = 1'b1; c.alu_op1 = 1'b1; end
         R_WB:     c.reg_write = 1'b1;
         CBZ: begin
            c.alu_src_a = 1'b1; c.alu_op0 = 1'b1; c.reg2_loc = 1'b1;
            c.pc_write_cond = 1'b1; c.pc_source = 2'b01;
         end
         BR:       begin c.pc_write = 1'b1; c.pc_source = 2'b10; end
         default:  c = '0;
      endcase
      return c;
   endfunction

   state_t            cur_state;
   state_t            nxt_state;
   ctrl_t             ctrl;
   logic              is_load;
   logic              halted;
   logic [CNT_W-1:0]  count;
   logic              op_rtype, op_ldur, op_stur, op_cbz, op_b;
   logic              last_cycle;

   // The zero flag gates the PC load in the datapath, not in this FSM.
   wire unused_zero = zero;

   // Opcode classification.
   always_comb begin
      op_rtype = (opcode == 11'b10001011000) || (opcode == 11'b11001011000) ||
                 (opcode == 11'b10001010000) || (opcode == 11'b10101010000);
      op_ldur  = (opcode == 11'b11111000010);
      op_stur  = (opcode == 11'b11111000000);
      op_cbz   = (opcode[10:3] == 8'b10110100);
      op_b     = (opcode[10:5] == 6'b000101);
   end

   // Next-state sequencing; the opcode only matters in DECODE.
   always_comb begin
      nxt_state = cur_state;
      case (cur_state)
         FETCH:    nxt_state = DECODE;
         DECODE: begin
            if (op_rtype)                nxt_state = R_EXEC;
            else if (op_ldur || op_stur) nxt_state = MEM_ADDR;
            else if (op_cbz)             nxt_state = CBZ;
            else if (op_b)               nxt_state = BR;
            else                         nxt_state = HALT;
         end
         MEM_ADDR: nxt_state = is_load ? MEM_RD : MEM_WR;
         MEM_RD:   nxt_state = MEM_WB;
         R_EXEC:   nxt_state = R_WB;
         MEM_WB, MEM_WR, R_WB, CBZ, BR: nxt_state = FETCH;
         HALT:     nxt_state = HALT;
         default:  nxt_state = FETCH;
      endcase
      last_cycle = (cur_state == MEM_WB) || (cur_state == MEM_WR) ||
                   (cur_state == R_WB)   || (cur_state == CBZ)    ||
                   (cur_state == BR);
   end

   // State, registered control word, load/store memo, sticky flag and counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_state <= FETCH;
         ctrl      <= ctrl_of(FETCH);
         is_load   <= 1'b0;
         halted    <= 1'b0;
         count     <= '0;
      end else begin
         cur_state <= nxt_state;
         ctrl      <= ctrl_of(nxt_state);
         if (cur_state == DECODE) is_load <= op_ldur;
         if (nxt_state == HALT)   halted  <= 1'b1;
         if (last_cycle)          count   <= count + CNT_ONE;
      end
   end

   assign pc_write      = ctrl.pc_write;
   assign pc_write_cond = ctrl.pc_write_cond;
   assign ir_write      = ctrl.ir_write;
   assign mem_read      = ctrl.mem_read;
   assign mem_write     = ctrl.mem_write;
   assign reg_write     = ctrl.reg_write;
   assign mem_to_reg    = ctrl.mem_to_reg;
   // In DECODE the IR has only just been loaded, so Rt selection follows the opcode directly.
   assign reg2_loc      = ctrl.reg2_loc | ((cur_state == DECODE) & (op_stur | op_cbz));
   assign alu_src_a     = ctrl.alu_src_a;
   assign alu_src_b     = ctrl.alu_src_b;
   assign pc_source     = ctrl.pc_source;
   assign alu_op1       = ctrl.alu_op1;
   assign alu_op0       = ctrl.alu_op0;
   assign illegal       = halted;
   assign state         = cur_state;
   assign retired       = count;

endmodule
`default_nettype wire
